mem_bist_ctrl: RTL and testbench
================================

Name: mem_bist_ctrl

Overview:
Initiator-side engine for the single-clock dual-address memory module (rd_en/wr_en, rd_addr/wr_addr, wr_data in; rd_data registered out). On a start pulse it runs a four-phase march over every address:
- write the true pattern;
- read it back and compare;
- write the inverted pattern;
- read it back and compare.

It reports pass/fail, a saturating error count and the first failing address. It sits beside each memory instance and owns that memory's ports while busy.

Parameters:
DATA_WIDTH, 8, memory word width; must match the memory instance.
MAX_ADDR, 16, number of words tested (addresses 0..MAX_ADDR-1); must be >= 2.
ADDRSIZE, $clog2(MAX_ADDR), memory address width.
ERR_W, 8, width of the error counter.

Ports:
clk  in  1  system clock; all state updates on posedge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle request; sampled only in IDLE and DONE.
seed  in  DATA_WIDTH  pattern base; captured on accepted start.
mem_rd_en  out  1  memory read enable.
mem_wr_en  out  1  memory write enable.
mem_rd_addr  out  ADDRSIZE  memory read address.
mem_wr_addr  out  ADDRSIZE  memory write address.
mem_wr_data  out  DATA_WIDTH  memory write data.
mem_rd_data  in  DATA_WIDTH  memory read data; valid one cycle after mem_rd_en.
busy  out  1  high while a test is running.
done  out  1  high from test end until the next accepted start.
pass  out  1  qualified by done; 1 means err_cnt == 0.
err_cnt  out  ERR_W  number of mismatches, saturating at all-ones.
first_err_addr  out  ADDRSIZE  address of the first mismatch; 0 if none.
first_err_phase  out  1  phase of the first mismatch: 0 = true-pattern read, 1 = inverted read.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0: enables, addresses, wr_data, busy, done, pass, err_cnt, first_err_*. The compare pipeline is cleared. Enables drop immediately, without waiting for a clock edge.
- States: IDLE, WR0, RD0, WR1, RD1, DRAIN, DONE.
- Accepting start:
  - IDLE or DONE with start=1: latch seed, clear err_cnt, first_err_* and done, set addr=0, go to WR0.
  - start in any other state is ignored.
- Pattern: P(a) = (seed + zero-extended a) mod 2^DATA_WIDTH. WR0/RD0 use P(a); WR1/RD1 use ~P(a).
- WR0/WR1: one word per cycle. mem_wr_en=1, mem_wr_addr=a, mem_wr_data=pattern. At a=MAX_ADDR-1 advance to the next phase with addr=0.
- RD0/RD1: one read per cycle. mem_rd_en=1, mem_rd_addr=a. After the last address, RD0 goes to WR1 and RD1 goes to DRAIN.
- Never assert mem_rd_en and mem_wr_en in the same cycle; the memory gives rd_en priority and would drop the write. Unused address/data outputs hold their last values.
- Compare pipeline:
  - Every issued read registers {valid, addr, expected, phase}.
  - On the next cycle, mem_rd_data is compared with expected, independent of the current state. The last RD0 compare therefore lands in WR1 cycle 0, and the last RD1 compare lands in DRAIN.
  - On mismatch: err_cnt increments, saturating at 2^ERR_W-1. If this is the first mismatch, capture the addr and phase.
- DRAIN: one cycle, no memory access. Then go to DONE: done=1, pass=(err_cnt==0).
- DONE holds all results until a new start is accepted.
- busy=1 in WR0..DRAIN, 0 in IDLE/DONE.
- Timing: start sampled at edge E0 means WR0 is active during cycle 1. busy is high for exactly 4*MAX_ADDR+1 cycles. done rises at edge E0+4*MAX_ADDR+1.
- Reset mid-test returns to IDLE with all results cleared; no memory access occurs after rst_n falls.

Test Plan:
- Clean run (DATA_WIDTH=8, MAX_ADDR=4, seed=0x10, ideal memory model):
  - WR0 writes 0x10,0x11,0x12,0x13 to addresses 0..3; WR1 writes 0xEF,0xEE,0xED,0xEC.
  - busy is high for 17 cycles, then done=1, pass=1, err_cnt=0.
  - Checker flags any cycle with both enables high.
- Wrap of pattern (seed=0xFE, MAX_ADDR=4) -> WR0 data 0xFE,0xFF,0x00,0x01; pass=1.
- Stuck-at fault (model forces bit0=1 at addr 2, seed=0x00):
  - RD0 expects 0x02 and reads 0x03, giving a mismatch; RD1 expects 0xFD, which already has bit0=1, so no mismatch.
  - Result: err_cnt=1, first_err_addr=2, first_err_phase=0, pass=0.
- Saturation (ERR_W=2, model returns 0x55 for every read, seed=0x00, MAX_ADDR=8) -> err_cnt=3, first_err_addr=0, pass=0.
- start pulsed during RD0 -> ignored: the sequence and the 17-cycle busy window are unchanged. A start in DONE restarts the test and clears done the next cycle.
- rst_n low for 1 cycle mid-WR1 -> enables drop asynchronously and all outputs read 0. A subsequent start runs a full clean test with pass=1.

Source files
------------

// File: rtl/mem_bist_ctrl.sv
// March-style BIST engine: writes seed-based pattern, reads it back, repeats inverted,
// and reports error count plus the first failing address and phase.

module mem_bist_chk (
  input logic clk,
  input logic rst_n,
  input logic rd_en,
  input logic wr_en,
  input logic busy,
  input logic done
);

  // The memory gives rd_en priority, so a simultaneous write would be lost.
  a_excl_en: assert property (@(posedge clk) disable iff (!rst_n) !(rd_en && wr_en));
  a_busy_done: assert property (@(posedge clk) disable iff (!rst_n) !(busy && done));

endmodule

module mem_bist_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_ADDR   = 16,
  parameter int ADDRSIZE   = $clog2(MAX_ADDR),
  parameter int ERR_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [ADDRSIZE-1:0]   mem_rd_addr,
  output logic [ADDRSIZE-1:0]   mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_cnt,
  output logic [ADDRSIZE-1:0]   first_err_addr,
  output logic                  first_err_phase
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR0   = 3'd1,
    RD0   = 3'd2,
    WR1   = 3'd3,
    RD1   = 3'd4,
    DRAIN = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [ADDRSIZE-1:0]   LAST_ADDR = ADDRSIZE'(MAX_ADDR - 1);
  localparam logic [ADDRSIZE-1:0]   ADDR_ZERO = {ADDRSIZE{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [ERR_W-1:0]      ERR_ZERO  = {ERR_W{1'b0}};
  localparam logic [ERR_W-1:0]      ERR_MAX   = {ERR_W{1'b1}};

  state_t                state_r;
  logic [ADDRSIZE-1:0]   addr_r;
  logic [DATA_WIDTH-1:0] seed_r;
  logic                  cmp_valid_r;
  logic [ADDRSIZE-1:0]   cmp_addr_r;
  logic [DATA_WIDTH-1:0] cmp_exp_r;
  logic                  cmp_phase_r;

  logic [ADDRSIZE-1:0]   addr_inc_s;
  logic                  last_s;
  logic                  mismatch_s;
  logic [ERR_W-1:0]      err_next_s;

  function automatic logic [DATA_WIDTH-1:0] pattern(
    input logic [DATA_WIDTH-1:0] base,
    input logic [ADDRSIZE-1:0]   a,
    input logic                  inv
  );
    logic [DATA_WIDTH-1:0] p;
    p = base + DATA_WIDTH'(a);
    return inv ? ~p : p;
  endfunction

  // Address stepping and the compare result for the read issued last cycle.
  always_comb begin
    addr_inc_s = addr_r + ADDRSIZE'(1'b1);
    last_s     = (addr_r == LAST_ADDR);
    mismatch_s = cmp_valid_r && (mem_rd_data != cmp_exp_r);
    if (mismatch_s && (err_cnt != ERR_MAX)) begin
      err_next_s = err_cnt + ERR_W'(1'b1);
    end else begin
      err_next_s = err_cnt;
    end
  end

  // Sequencer, memory port drivers, compare pipeline and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      addr_r          <= ADDR_ZERO;
      seed_r          <= DATA_ZERO;
      cmp_valid_r     <= 1'b0;
      cmp_addr_r      <= ADDR_ZERO;
      cmp_exp_r       <= DATA_ZERO;
      cmp_phase_r     <= 1'b0;
      mem_rd_en       <= 1'b0;
      mem_wr_en       <= 1'b0;
      mem_rd_addr     <= ADDR_ZERO;
      mem_wr_addr     <= ADDR_ZERO;
      mem_wr_data     <= DATA_ZERO;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_cnt         <= ERR_ZERO;
      first_err_addr  <= ADDR_ZERO;
      first_err_phase <= 1'b0;
    end else begin
      // Pipeline runs regardless of state so the trailing compares land in WR1/DRAIN.
      cmp_valid_r <= mem_rd_en;
      if (mem_rd_en) begin
        cmp_addr_r  <= mem_rd_addr;
        cmp_exp_r   <= pattern(seed_r, mem_rd_addr, state_r == RD1);
        cmp_phase_r <= (state_r == RD1);
      end else begin
        cmp_addr_r  <= cmp_addr_r;
        cmp_exp_r   <= cmp_exp_r;
        cmp_phase_r <= cmp_phase_r;
      end

      err_cnt <= err_next_s;
      // err_cnt saturates and never returns to zero, so zero means no earlier mismatch.
      if (mismatch_s && (err_cnt == ERR_ZERO)) begin
        first_err_addr  <= cmp_addr_r;
        first_err_phase <= cmp_phase_r;
      end else begin
        first_err_addr  <= first_err_addr;
        first_err_phase <= first_err_phase;
      end

      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            seed_r          <= seed;
            err_cnt         <= ERR_ZERO;
            first_err_addr  <= ADDR_ZERO;
            first_err_phase <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            busy            <= 1'b1;
            addr_r          <= ADDR_ZERO;
            mem_wr_en       <= 1'b1;
            mem_wr_addr     <= ADDR_ZERO;
            mem_wr_data     <= pattern(seed, ADDR_ZERO, 1'b0);
            state_r         <= WR0;
          end else begin
            state_r <= state_r;
          end
        end
        WR0, WR1: begin
          if (last_s) begin
            addr_r      <= ADDR_ZERO;
            mem_wr_en   <= 1'b0;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= ADDR_ZERO;
            state_r     <= (state_r == WR0) ? RD0 : RD1;
          end else begin
            addr_r      <= addr_inc_s;
            mem_wr_addr <= addr_inc_s;
            mem_wr_data <= pattern(seed_r, addr_inc_s, state_r == WR1);
          end
        end
        RD0: begin
          if (last_s) begin
            addr_r      <= ADDR_ZERO;
            mem_rd_en   <= 1'b0;
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= ADDR_ZERO;
            mem_wr_data <= pattern(seed_r, ADDR_ZERO, 1'b1);
            state_r     <= WR1;
          end else begin
            addr_r      <= addr_inc_s;
            mem_rd_addr <= addr_inc_s;
          end
        end
        RD1: begin
          if (last_s) begin
            addr_r    <= ADDR_ZERO;
            mem_rd_en <= 1'b0;
            state_r   <= DRAIN;
          end else begin
            addr_r      <= addr_inc_s;
            mem_rd_addr <= addr_inc_s;
          end
        end
        DRAIN: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          pass    <= (err_next_s == ERR_ZERO);
          state_r <= DONE;
        end
        default: begin
          mem_rd_en <= 1'b0;
          mem_wr_en <= 1'b0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  mem_bist_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .rd_en (mem_rd_en),
    .wr_en (mem_wr_en),
    .busy  (busy),
    .done  (done)
  );

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Scoreboard bench for mem_bist_ctrl: stimulus pushes expected writes, reads and final
// results; a negedge monitor pops and compares them as the DUT presents them.

module tb_mem_bist_ctrl;

  localparam int DW  = 8;
  localparam int N   = 4;
  localparam int AW  = 2;
  localparam int EW  = 8;
  localparam int N2  = 8;
  localparam int AW2 = 3;
  localparam int EW2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start;
  logic [DW-1:0] seed;
  logic          mem_rd_en, mem_wr_en;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data = 8'h00;
  logic          busy, done, pass, first_err_phase;
  logic [EW-1:0] err_cnt;
  logic [AW-1:0] first_err_addr;

  logic           s_start;
  logic [DW-1:0]  s_seed;
  logic           s_rd_en, s_wr_en, s_busy, s_done, s_pass, s_fphase;
  logic [AW2-1:0] s_rd_addr, s_wr_addr, s_faddr;
  logic [DW-1:0]  s_wr_data;
  logic [DW-1:0]  s_rd_data = 8'h00;
  logic [EW2-1:0] s_err;

  mem_bist_ctrl #(.DATA_WIDTH(DW), .MAX_ADDR(N), .ADDRSIZE(AW), .ERR_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr), .first_err_phase(first_err_phase)
  );

  mem_bist_ctrl #(.DATA_WIDTH(DW), .MAX_ADDR(N2), .ADDRSIZE(AW2), .ERR_W(EW2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(s_start), .seed(s_seed),
    .mem_rd_en(s_rd_en), .mem_wr_en(s_wr_en),
    .mem_rd_addr(s_rd_addr), .mem_wr_addr(s_wr_addr),
    .mem_wr_data(s_wr_data), .mem_rd_data(s_rd_data),
    .busy(s_busy), .done(s_done), .pass(s_pass), .err_cnt(s_err),
    .first_err_addr(s_faddr), .first_err_phase(s_fphase)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory model with an optional single stuck bit applied on read.
  logic [DW-1:0] mem [N];
  bit fault_en  = 1'b0;
  int fault_addr = 0;
  int fault_bit  = 0;
  bit fault_val  = 1'b0;

  function automatic logic [DW-1:0] faulty(input logic [DW-1:0] v, input int a);
    logic [DW-1:0] r;
    r = v;
    if (fault_en && a == fault_addr) r[fault_bit] = fault_val;
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= faulty(mem[mem_rd_addr], int'(mem_rd_addr));
    else if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
  end

  always @(posedge clk) begin
    if (s_rd_en) s_rd_data <= 8'h55;
  end

  // Reference model and scoreboard queues
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct packed { logic [EW-1:0] err; logic [AW-1:0] fa; logic fp; logic ps; logic [15:0] blen; } res_t;
  wr_t           wr_q[$];
  logic [AW-1:0] rd_q[$];
  res_t          res_q[$];

  function automatic logic [DW-1:0] pat(input logic [DW-1:0] s, input int a, input bit inv);
    logic [DW-1:0] p;
    p = s + DW'(a);
    return inv ? ~p : p;
  endfunction

  task automatic push_expect(input logic [DW-1:0] s);
    int   errs;
    res_t r;
    logic [DW-1:0] e;
    errs = 0;
    r    = '0;
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < N; a++) wr_q.push_back({AW'(a), pat(s, a, p != 0)});
      for (int a = 0; a < N; a++) begin
        rd_q.push_back(AW'(a));
        e = pat(s, a, p != 0);
        if (faulty(e, a) != e) begin
          if (errs == 0) begin r.fa = AW'(a); r.fp = (p != 0); end
          errs++;
        end
      end
    end
    r.err  = (errs > 255) ? 8'hFF : EW'(errs);
    r.ps   = (errs == 0);
    r.blen = 16'(4 * N + 1);
    res_q.push_back(r);
  endtask

  // Monitor: pops expectations whenever the DUT drives the memory or finishes.
  bit busy_prev = 1'b0;
  bit done_prev = 1'b0;
  int busy_len  = 0;
  always @(negedge clk) begin
    wr_t  w;
    res_t r;
    if (rst_n) begin
      check("dual_en", 32'(mem_rd_en && mem_wr_en), 32'd0);
      check("sat_dual_en", 32'(s_rd_en && s_wr_en), 32'd0);
      if (mem_wr_en) begin
        check("wr_expected", 32'(wr_q.size() > 0), 32'd1);
        if (wr_q.size() > 0) begin
          w = wr_q.pop_front();
          check("wr_addr", 32'(mem_wr_addr), 32'(w.a));
          check("wr_data", 32'(mem_wr_data), 32'(w.d));
        end
      end
      if (mem_rd_en) begin
        check("rd_expected", 32'(rd_q.size() > 0), 32'd1);
        if (rd_q.size() > 0) check("rd_addr", 32'(mem_rd_addr), 32'(rd_q.pop_front()));
      end
      if (busy) begin
        if (!busy_prev) busy_len = 0;
        busy_len++;
      end
      if (done && !done_prev) begin
        check("res_expected", 32'(res_q.size() > 0), 32'd1);
        if (res_q.size() > 0) begin
          r = res_q.pop_front();
          check("err_cnt", 32'(err_cnt), 32'(r.err));
          check("first_err_addr", 32'(first_err_addr), 32'(r.fa));
          check("first_err_phase", 32'(first_err_phase), 32'(r.fp));
          check("pass", 32'(pass), 32'(r.ps));
          check("busy_len", 32'(busy_len), 32'(r.blen));
          check("busy_low_at_done", 32'(busy), 32'd0);
          check("wr_all_seen", 32'(wr_q.size()), 32'd0);
          check("rd_all_seen", 32'(rd_q.size()), 32'd0);
        end
      end
    end
    busy_prev = busy;
    done_prev = done;
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_en"}, 32'({mem_rd_en, mem_wr_en}), 32'd0);
    check({tag, "_addr"}, 32'({mem_rd_addr, mem_wr_addr}), 32'd0);
    check({tag, "_wdata"}, 32'(mem_wr_data), 32'd0);
    check({tag, "_flags"}, 32'({busy, done, pass}), 32'd0);
    check({tag, "_err"}, 32'({err_cnt, first_err_addr, first_err_phase}), 32'd0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && !done; i++) @(negedge clk);
    check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic run_test(input logic [DW-1:0] s, input bit poke_rd0);
    @(posedge clk); #1;
    seed  = s;
    start = 1'b1;
    push_expect(s);
    @(posedge clk); #1;
    start = 1'b0;
    seed  = DW'($urandom);
    @(negedge clk);
    check("start_busy", 32'(busy), 32'd1);
    check("start_done_clr", 32'(done), 32'd0);
    if (poke_rd0) begin
      repeat (N) @(posedge clk);
      #1;
      start = 1'b1;
      seed  = s ^ 8'h5A;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_done();
    @(posedge clk);
  endtask

  initial begin
    int errs;
    int fa, fp;
    logic [DW-1:0] e;
    rst_n   = 1'b0;
    start   = 1'b0;
    seed    = 8'h00;
    s_start = 1'b0;
    s_seed  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;

    run_test(8'h10, 1'b0);
    run_test(8'hFE, 1'b0);
    fault_en = 1'b1; fault_addr = 2; fault_bit = 0; fault_val = 1'b1;
    run_test(8'h00, 1'b0);
    check("stuck_err", 32'(err_cnt), 32'd1);
    check("stuck_addr", 32'(first_err_addr), 32'd2);
    check("stuck_pass", 32'(pass), 32'd0);
    fault_en = 1'b0;
    run_test(8'h37, 1'b1);

    for (int k = 0; k < 10; k++) begin
      fault_en   = bit'($urandom_range(0, 1));
      fault_addr = int'($urandom_range(0, N - 1));
      fault_bit  = int'($urandom_range(0, DW - 1));
      fault_val  = bit'($urandom_range(0, 1));
      run_test(DW'($urandom), bit'($urandom_range(0, 1)));
    end

    // Reset in the middle of WR1 after an RD0 error has been recorded.
    fault_en = 1'b1; fault_addr = 0; fault_bit = 0; fault_val = 1'b1;
    @(posedge clk); #1;
    seed  = 8'h00;
    start = 1'b1;
    push_expect(8'h00);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2 * N + 1) @(posedge clk);
    #2;
    check("pre_reset_wr1", 32'({mem_wr_en, err_cnt}), 32'({1'b1, 8'h01}));
    rst_n = 1'b0;
    wr_q.delete();
    rd_q.delete();
    res_q.delete();
    #1;
    check_zero_outputs("midreset");
    @(posedge clk); #2;
    rst_n    = 1'b1;
    fault_en = 1'b0;
    run_test(DW'($urandom), 1'b0);
    check("post_reset_pass", 32'(pass), 32'd1);

    // Saturating counter on the narrow instance, memory always returns 0x55.
    @(posedge clk); #1;
    s_seed  = 8'h00;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int i = 0; i < 200 && !s_done; i++) @(negedge clk);
    check("sat_done_timeout", 32'(s_done), 32'd1);
    errs = 0; fa = 0; fp = 0;
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < N2; a++) begin
        e = pat(8'h00, a, p != 0);
        if (e != 8'h55) begin
          if (errs == 0) begin fa = a; fp = p; end
          errs++;
        end
      end
    end
    check("sat_err_cnt", 32'(s_err), 32'((errs > 3) ? 3 : errs));
    check("sat_first_addr", 32'(s_faddr), 32'(fa));
    check("sat_first_phase", 32'(s_fphase), 32'(fp));
    check("sat_pass", 32'(s_pass), 32'(errs == 0));

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
